// File: rtl/c2n_multicast_sequencer.sv
// Multicast-to-unicast sequencer: latches one service message plus a tile mask and
// replays the payload once per set mask bit, lowest tile first, under downstream backpressure.
module c2n_multicast_sequencer #(
    parameter int DEST_WIDTH = 16,
    parameter int MSG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MSG_WIDTH-1:0]  in_message,
    input  logic [DEST_WIDTH-1:0] in_destination,
    input  logic                  in_valid,
    output logic                  in_available,
    input  logic                  network_available,
    output logic [MSG_WIDTH-1:0]  message_out,
    output logic                  message_out_valid,
    output logic [DEST_WIDTH-1:0] destination_valid,
    output logic                  message_out_last,
    output logic                  busy,
    output logic                  empty_mask_err,
    output logic                  protocol_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [DEST_WIDTH-1:0] DEST_ZERO = {DEST_WIDTH{1'b0}};
    localparam logic [DEST_WIDTH-1:0] DEST_ONE  = {{(DEST_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MSG_WIDTH-1:0]  MSG_ZERO  = {MSG_WIDTH{1'b0}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MSG_WIDTH-1:0]  r_msg;
    logic [MSG_WIDTH-1:0]  w_msg_nxt;
    logic [DEST_WIDTH-1:0] r_pending;
    logic [DEST_WIDTH-1:0] w_pending_nxt;
    logic                  r_empty_err;
    logic                  w_empty_err_nxt;
    logic                  r_protocol_err;
    logic                  w_protocol_err_nxt;
    logic [DEST_WIDTH-1:0] w_sel;
    logic [DEST_WIDTH-1:0] w_rest;

    // Two's-complement trick isolates the lowest set bit of the pending mask.
    assign w_sel  = r_pending & (~r_pending + DEST_ONE);
    assign w_rest = r_pending & ~w_sel;

    assign empty_mask_err = r_empty_err;
    assign protocol_err   = r_protocol_err;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_msg          <= MSG_ZERO;
            r_pending      <= DEST_ZERO;
            r_empty_err    <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_msg          <= w_msg_nxt;
            r_pending      <= w_pending_nxt;
            r_empty_err    <= w_empty_err_nxt;
            r_protocol_err <= w_protocol_err_nxt;
        end
    end

    // Next-state and beat outputs; network_available only affects outputs while sending.
    always_comb begin
        w_state_nxt        = r_state;
        w_msg_nxt          = r_msg;
        w_pending_nxt      = r_pending;
        w_empty_err_nxt    = 1'b0;
        w_protocol_err_nxt = r_protocol_err;
        in_available       = 1'b0;
        busy               = 1'b0;
        message_out        = MSG_ZERO;
        message_out_valid  = 1'b0;
        destination_valid  = DEST_ZERO;
        message_out_last   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_available = 1'b1;
                if (in_valid) begin
                    if (in_destination != DEST_ZERO) begin
                        w_msg_nxt     = in_message;
                        w_pending_nxt = in_destination;
                        w_state_nxt   = ST_SEND;
                    end else begin
                        w_empty_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy              = 1'b1;
                message_out       = r_msg;
                message_out_valid = network_available;
                if (in_valid) begin
                    w_protocol_err_nxt = 1'b1;
                end else begin
                    w_protocol_err_nxt = r_protocol_err;
                end
                if (network_available) begin
                    destination_valid = w_sel;
                    message_out_last  = (w_rest == DEST_ZERO);
                    w_pending_nxt     = w_rest;
                    if (w_rest == DEST_ZERO) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end else begin
                    w_pending_nxt = r_pending;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = DEST_ZERO;
            end
        endcase
    end

endmodule
